// File: rtl/ahb_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_pkg
// Description : Shared AHB codes, FSM state encoding and byte-lane mask helper
//               for the banked byte-lane SRAM slave front end.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_sram_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [1:0] HRESP_OKAY  = 2'd0;
   localparam logic [1:0] HRESP_ERROR = 2'd1;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_RD   = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_t;

   // Active-low lane mask; bits at or above nb are always 1.
   function automatic logic [7:0] lane_mask(input logic [2:0] hsize,
                                            input logic [2:0] lane,
                                            input logic       big_endian,
                                            input int unsigned nb);
      logic [7:0]  mask;
      int unsigned cnt;
      int unsigned first;
      int unsigned phys;
      mask  = 8'hFF;
      cnt   = 32'd1 << hsize;
      first = 32'(lane);
      if (cnt >= nb) begin
         cnt   = nb;
         first = 0;
      end
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < nb && i >= first && i < first + cnt) begin
            phys = big_endian ? (nb - 1 - i) : i;
            mask[phys[2:0]] = 1'b0;
         end
      end
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_lane_dec.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_lane_dec
// Description : Transfer size / lane select to NB-bit active-low lane mask.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_lane_dec
   import ahb_sram_pkg::*;
#(
   parameter int NB         = 4,
   parameter int BIG_ENDIAN = 1
) (
   input  logic [2:0]            hsize,
   input  logic [$clog2(NB)-1:0] lane,
   output logic [NB-1:0]         csn_mask
);

   logic [7:0] w_mask;

   assign w_mask   = lane_mask(hsize, 3'(lane), BIG_ENDIAN != 0, NB);
   assign csn_mask = w_mask[NB-1:0];

   generate
      if (NB < 8) begin : g_pad
         logic w_unused;
         assign w_unused = &w_mask[7:NB];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave_if_p.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_slave_if_p
// Description : Parametrised AHB-Lite slave front end for banked byte-lane SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_slave_if_p
   import ahb_sram_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int NUM_BANKS  = 2,
   parameter int BANK_AW    = 13,
   parameter int RD_WAIT    = 0,
   parameter int BIG_ENDIAN = 1
) (
   input  logic                          hclk,
   input  logic                          hrstn,
   input  logic                          hsel,
   input  logic [1:0]                    htrans,
   input  logic [2:0]                    hsize,
   input  logic [2:0]                    hburst,
   input  logic                          hwrite,
   input  logic [31:0]                   haddr,
   input  logic                          hready_in,
   input  logic [DATA_W-1:0]             hwdata,
   output logic                          hready_out,
   output logic [1:0]                    hresp,
   output logic [DATA_W-1:0]             hrdata,
   input  logic [NUM_BANKS*DATA_W-1:0]   sram_q,
   output logic [NUM_BANKS*DATA_W/8-1:0] bank_csn,
   output logic                          sram_we,
   output logic [BANK_AW-1:0]            sram_addr,
   output logic [DATA_W-1:0]             sram_wdata
);

   localparam int NB = DATA_W / 8;
   localparam int LB = $clog2(NB);
   localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   state_t                    r_state;
   logic                      r_hready;
   logic [1:0]                r_hresp;
   logic [NUM_BANKS*NB-1:0]   r_csn;
   logic                      r_we;
   logic [BANK_AW-1:0]        r_addr;
   logic [BW-1:0]             r_bank;
   logic                      r_rd_last;
   logic [1:0]                r_wait_cnt;

   logic                      w_accept;
   logic                      w_illegal;
   logic [LB-1:0]             w_size_lsbs;
   logic [BW-1:0]             w_bank;
   logic [NB-1:0]             w_lane_csn;
   logic [NUM_BANKS*NB-1:0]   w_csn_next;
   logic [DATA_W-1:0]         w_q_bank [NUM_BANKS];
   logic                      w_unused;

   assign w_accept    = hsel & hready_in & r_hready & htrans[1];
   assign w_size_lsbs = LB'((32'd1 << hsize) - 32'd1);
   assign w_illegal   = (hsize > 3'(LB)) | (|(haddr[LB-1:0] & w_size_lsbs));
   assign w_unused    = ^{hburst, htrans[0], haddr};

   generate
      if (NUM_BANKS > 1) begin : g_bank_multi
         assign w_bank = haddr[LB+BANK_AW +: BW];
      end else begin : g_bank_single
         assign w_bank = '0;
      end
      for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_q
         assign w_q_bank[gi] = sram_q[gi*DATA_W +: DATA_W];
      end
   endgenerate

   ahb_sram_lane_dec #(
      .NB         (NB),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_lane_dec (
      .hsize    (hsize),
      .lane     (haddr[LB-1:0]),
      .csn_mask (w_lane_csn)
   );

   always_comb begin
      w_csn_next = '1;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (BW'(b) == w_bank) w_csn_next[b*NB +: NB] = w_lane_csn;
      end
   end

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         r_state    <= ST_IDLE;
         r_hready   <= 1'b1;
         r_hresp    <= HRESP_OKAY;
         r_csn      <= '1;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_bank     <= '0;
         r_rd_last  <= 1'b0;
         r_wait_cnt <= '0;
      end else begin
         r_rd_last <= 1'b0;
         if (r_hready) begin
            // Bus is free: the next state follows the address phase on the bus.
            r_hresp    <= HRESP_OKAY;
            r_we       <= 1'b0;
            r_csn      <= '1;
            r_wait_cnt <= '0;
            if (w_accept) begin
               if (w_illegal) begin
                  r_state  <= ST_ERR1;
                  r_hready <= 1'b0;
                  r_hresp  <= HRESP_ERROR;
               end else begin
                  r_addr <= haddr[LB +: BANK_AW];
                  r_bank <= w_bank;
                  r_csn  <= w_csn_next;
                  if (hwrite) begin
                     r_state <= ST_WR;
                     r_we    <= 1'b1;
                  end else begin
                     r_state  <= ST_RD;
                     r_hready <= 1'b0;
                  end
               end
            end else begin
               r_state <= ST_IDLE;
            end
         end else begin
            case (r_state)
               ST_RD: begin
                  if (r_wait_cnt == 2'(RD_WAIT)) begin
                     r_hready  <= 1'b1;
                     r_rd_last <= 1'b1;
                  end else begin
                     r_wait_cnt <= r_wait_cnt + 2'd1;
                  end
               end
               ST_ERR1: begin
                  r_state  <= ST_ERR2;
                  r_hready <= 1'b1;
               end
               default: r_hready <= 1'b1;
            endcase
         end
      end
   end

   assign hready_out = r_hready;
   assign hresp      = r_hresp;
   assign bank_csn   = r_csn;
   assign sram_we    = r_we;
   assign sram_addr  = r_addr;
   assign sram_wdata = hwdata;
   // q is valid only in the last read cycle, one cycle after the address.
   assign hrdata     = r_rd_last ? w_q_bank[r_bank] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave_if_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_sram_slave_if_p
// Description : Directed table-driven bench for ahb_sram_slave_if_p.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave_if_p;

   logic        hclk = 1'b0;
   logic        hrstn;
   logic        hsel_a, hsel_b, hwrite, hready_in;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;
   logic [31:0] haddr;
   logic [63:0] hwdata;

   logic        hready_a, we_a;
   logic [1:0]  hresp_a;
   logic [31:0] hrdata_a, wdata_a;
   logic [63:0] q_a;
   logic [7:0]  csn_a;
   logic [12:0] addr_a;

   logic        hready_b, we_b;
   logic [1:0]  hresp_b;
   logic [63:0] hrdata_b, wdata_b;
   logic [255:0] q_b;
   logic [31:0] csn_b;
   logic [13:0] addr_b;

   int checks = 0;
   int failures = 0;

   always #5 hclk = ~hclk;

   ahb_sram_slave_if_p #(.DATA_W(32), .NUM_BANKS(2), .BANK_AW(13), .RD_WAIT(2), .BIG_ENDIAN(1)) dut_a (
      .hclk(hclk), .hrstn(hrstn), .hsel(hsel_a), .htrans(htrans), .hsize(hsize), .hburst(hburst),
      .hwrite(hwrite), .haddr(haddr), .hready_in(hready_in), .hwdata(hwdata[31:0]),
      .hready_out(hready_a), .hresp(hresp_a), .hrdata(hrdata_a), .sram_q(q_a),
      .bank_csn(csn_a), .sram_we(we_a), .sram_addr(addr_a), .sram_wdata(wdata_a));

   ahb_sram_slave_if_p #(.DATA_W(64), .NUM_BANKS(4), .BANK_AW(14), .RD_WAIT(0), .BIG_ENDIAN(1)) dut_b (
      .hclk(hclk), .hrstn(hrstn), .hsel(hsel_b), .htrans(htrans), .hsize(hsize), .hburst(hburst),
      .hwrite(hwrite), .haddr(haddr), .hready_in(hready_in), .hwdata(hwdata),
      .hready_out(hready_b), .hresp(hresp_b), .hrdata(hrdata_b), .sram_q(q_b),
      .bank_csn(csn_b), .sram_we(we_b), .sram_addr(addr_b), .sram_wdata(wdata_b));

   // Synchronous SRAM models with per-byte-lane chip selects.
   logic [31:0] mem_a [2][16];
   logic [63:0] mem_b [4][16];

   always @(posedge hclk) begin
      if (!hrstn) begin
         for (int b = 0; b < 2; b++) for (int w = 0; w < 16; w++) mem_a[b][w] <= '0;
         mem_a[0][1] <= 32'h1234_5678;
         q_a <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (csn_a[b*4 +: 4] != 4'hF) begin
               if (we_a) begin
                  for (int j = 0; j < 4; j++)
                     if (!csn_a[b*4+j]) mem_a[b][addr_a[3:0]][j*8 +: 8] <= wdata_a[j*8 +: 8];
               end else begin
                  q_a[b*32 +: 32] <= mem_a[b][addr_a[3:0]];
               end
            end
         end
      end
   end

   always @(posedge hclk) begin
      if (!hrstn) begin
         for (int b = 0; b < 4; b++) for (int w = 0; w < 16; w++) mem_b[b][w] <= '0;
         q_b <= '0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (csn_b[b*8 +: 8] != 8'hFF) begin
               if (we_b) begin
                  for (int j = 0; j < 8; j++)
                     if (!csn_b[b*8+j]) mem_b[b][addr_b[3:0]][j*8 +: 8] <= wdata_b[j*8 +: 8];
               end else begin
                  q_b[b*64 +: 64] <= mem_b[b][addr_b[3:0]];
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   // Single word read on dut_a (RD_WAIT=2); hsel drops once the data phase starts.
   task automatic read_a(input logic [31:0] a, input logic [31:0] exp, input logic [7:0] ecsn);
      hsel_a = 1'b1; htrans = 2'd2; hwrite = 1'b0; hsize = 3'd2; haddr = a;
      tick();
      hsel_a = 1'b0; htrans = 2'd0;
      chk("rd_c1_hready", 64'(hready_a), 64'd0);
      chk("rd_c1_csn", 64'(csn_a), 64'(ecsn));
      chk("rd_c1_addr", 64'(addr_a), 64'(a[14:2]));
      chk("rd_c1_hrdata", 64'(hrdata_a), 64'd0);
      tick();
      chk("rd_c2_hready", 64'(hready_a), 64'd0);
      tick();
      chk("rd_c3_hready", 64'(hready_a), 64'd0);
      chk("rd_c3_csn", 64'(csn_a), 64'(ecsn));
      tick();
      chk("rd_c4_hready", 64'(hready_a), 64'd1);
      chk("rd_c4_hrdata", 64'(hrdata_a), 64'(exp));
      tick();
      chk("rd_done_hrdata", 64'(hrdata_a), 64'd0);
      chk("rd_done_csn", 64'(csn_a), 64'hFF);
   endtask

   typedef struct {
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [12:0] eaddr;
      logic [7:0]  ecsn;
   } vec_t;

   vec_t vecs [11];
   logic [63:0] bd [4];

   initial begin
      vecs[0]  = '{1'b1, 3'd2, 32'h0000_8004, 32'hDEAD_BEEF, 1'b0, 13'd1,      8'h0F};
      vecs[1]  = '{1'b1, 3'd0, 32'h0000_0002, 32'h1111_1111, 1'b0, 13'd0,      8'hFD};
      vecs[2]  = '{1'b1, 3'd1, 32'h0000_0002, 32'h2222_2222, 1'b0, 13'd0,      8'hFC};
      vecs[3]  = '{1'b1, 3'd0, 32'h0000_0000, 32'h3333_3333, 1'b0, 13'd0,      8'hF7};
      vecs[4]  = '{1'b1, 3'd0, 32'h0000_0003, 32'h4444_4444, 1'b0, 13'd0,      8'hFE};
      vecs[5]  = '{1'b1, 3'd1, 32'h0000_0000, 32'h5555_5555, 1'b0, 13'd0,      8'hF3};
      vecs[6]  = '{1'b1, 3'd2, 32'h0001_0008, 32'h6666_6666, 1'b0, 13'd2,      8'hF0};
      vecs[7]  = '{1'b1, 3'd2, 32'h0000_FFFC, 32'h7777_7777, 1'b0, 13'h1FFF,   8'h0F};
      vecs[8]  = '{1'b1, 3'd1, 32'h0000_0001, 32'h0,         1'b1, 13'd0,      8'hFF};
      vecs[9]  = '{1'b1, 3'd3, 32'h0000_0000, 32'h0,         1'b1, 13'd0,      8'hFF};
      vecs[10] = '{1'b0, 3'd2, 32'h0000_0002, 32'h0,         1'b1, 13'd0,      8'hFF};
      bd[0] = 64'h0123_4567_89AB_CDEF;
      bd[1] = 64'hFEDC_BA98_7654_3210;
      bd[2] = 64'hA5A5_5A5A_C3C3_3C3C;
      bd[3] = 64'h0F0F_F0F0_1122_3344;

      hrstn = 1'b0; hsel_a = 1'b0; hsel_b = 1'b0; hready_in = 1'b1;
      htrans = 2'd0; hsize = 3'd0; hburst = 3'd0; hwrite = 1'b0; haddr = '0; hwdata = '0;
      repeat (3) tick();
      chk("rst_hready", 64'(hready_a), 64'd1);
      chk("rst_hresp", 64'(hresp_a), 64'd0);
      chk("rst_csn", 64'(csn_a), 64'hFF);
      chk("rst_we", 64'(we_a), 64'd0);
      chk("rst_addr", 64'(addr_a), 64'd0);
      chk("rst_hrdata", 64'(hrdata_a), 64'd0);
      chk("rst_csn_b", 64'(csn_b), 64'hFFFF_FFFF);
      hrstn = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         hsel_a = 1'b1; htrans = 2'd2; hwrite = vecs[i].wr; hsize = vecs[i].size; haddr = vecs[i].addr;
         tick();
         hsel_a = 1'b0; htrans = 2'd0; hwdata = {32'h0, vecs[i].wdata};
         if (!vecs[i].err) begin
            chk($sformatf("v%0d_we", i), 64'(we_a), 64'd1);
            chk($sformatf("v%0d_addr", i), 64'(addr_a), 64'(vecs[i].eaddr));
            chk($sformatf("v%0d_csn", i), 64'(csn_a), 64'(vecs[i].ecsn));
            chk($sformatf("v%0d_hready", i), 64'(hready_a), 64'd1);
            chk($sformatf("v%0d_hresp", i), 64'(hresp_a), 64'd0);
            chk($sformatf("v%0d_wdata", i), 64'(wdata_a), 64'(vecs[i].wdata));
         end else begin
            chk($sformatf("v%0d_e1_hready", i), 64'(hready_a), 64'd0);
            chk($sformatf("v%0d_e1_hresp", i), 64'(hresp_a), 64'd1);
            chk($sformatf("v%0d_e1_csn", i), 64'(csn_a), 64'hFF);
            chk($sformatf("v%0d_e1_we", i), 64'(we_a), 64'd0);
         end
         tick();
         if (!vecs[i].err) begin
            chk($sformatf("v%0d_after_we", i), 64'(we_a), 64'd0);
            chk($sformatf("v%0d_after_csn", i), 64'(csn_a), 64'hFF);
         end else begin
            chk($sformatf("v%0d_e2_hready", i), 64'(hready_a), 64'd1);
            chk($sformatf("v%0d_e2_hresp", i), 64'(hresp_a), 64'd1);
            chk($sformatf("v%0d_e2_csn", i), 64'(csn_a), 64'hFF);
         end
      end
      tick();
      chk("post_err_hresp", 64'(hresp_a), 64'd0);

      read_a(32'h0000_0004, 32'h1234_5678, 8'hF0);
      read_a(32'h0000_0000, 32'h5555_2244, 8'hF0);
      read_a(32'h0000_8004, 32'hDEAD_BEEF, 8'h0F);

      // Write data phase overlapping the address phase of a read to the same word.
      hsel_a = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h4;
      tick();
      hwdata = {32'h0, 32'hCAFE_F00D}; hwrite = 1'b0;
      chk("raw_wr_we", 64'(we_a), 64'd1);
      tick();
      hsel_a = 1'b0; htrans = 2'd0;
      chk("raw_rd_hready", 64'(hready_a), 64'd0);
      chk("raw_rd_we", 64'(we_a), 64'd0);
      chk("raw_rd_csn", 64'(csn_a), 64'hF0);
      repeat (3) tick();
      chk("raw_rd_last_hready", 64'(hready_a), 64'd1);
      chk("raw_rd_data", 64'(hrdata_a), 64'hCAFE_F00D);
      tick();

      // Reset asserted in the middle of a read.
      hsel_a = 1'b1; htrans = 2'd2; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h4;
      tick();
      hsel_a = 1'b0; htrans = 2'd0;
      chk("mid_rd_hready", 64'(hready_a), 64'd0);
      hrstn = 1'b0;
      #1;
      chk("mid_rst_hready", 64'(hready_a), 64'd1);
      chk("mid_rst_csn", 64'(csn_a), 64'hFF);
      chk("mid_rst_we", 64'(we_a), 64'd0);
      chk("mid_rst_hresp", 64'(hresp_a), 64'd0);
      chk("mid_rst_addr", 64'(addr_a), 64'd0);
      chk("mid_rst_hrdata", 64'(hrdata_a), 64'd0);
      tick();
      hrstn = 1'b1;
      repeat (3) tick();
      chk("after_rst_hready", 64'(hready_a), 64'd1);

      // 64-bit, 4-bank INCR4 burst with a BUSY beat; bank index from haddr[18:17].
      hsel_b = 1'b1; hwrite = 1'b1; hsize = 3'd3; hburst = 3'd3;
      htrans = 2'd2; haddr = 32'h0004_0010;
      tick();
      htrans = 2'd3; haddr = 32'h0004_0018; hwdata = bd[0];
      chk("b_w0_we", 64'(we_b), 64'd1);
      chk("b_w0_addr", 64'(addr_b), 64'd2);
      chk("b_w0_csn", 64'(csn_b), 64'hFF00_FFFF);
      tick();
      htrans = 2'd1; haddr = 32'h0004_0020; hwdata = bd[1];
      chk("b_w1_we", 64'(we_b), 64'd1);
      chk("b_w1_addr", 64'(addr_b), 64'd3);
      tick();
      htrans = 2'd3; haddr = 32'h0004_0020; hwdata = '0;
      chk("b_busy_we", 64'(we_b), 64'd0);
      chk("b_busy_csn", 64'(csn_b), 64'hFFFF_FFFF);
      chk("b_busy_hready", 64'(hready_b), 64'd1);
      chk("b_busy_hresp", 64'(hresp_b), 64'd0);
      tick();
      htrans = 2'd3; haddr = 32'h0004_0028; hwdata = bd[2];
      chk("b_w2_we", 64'(we_b), 64'd1);
      chk("b_w2_addr", 64'(addr_b), 64'd4);
      tick();
      htrans = 2'd0; hwdata = bd[3];
      chk("b_w3_we", 64'(we_b), 64'd1);
      chk("b_w3_addr", 64'(addr_b), 64'd5);
      chk("b_w3_csn", 64'(csn_b), 64'hFF00_FFFF);
      tick();
      chk("b_end_we", 64'(we_b), 64'd0);
      for (int k = 0; k < 4; k++) chk($sformatf("b_mem%0d", k), mem_b[2][k+2], bd[k]);

      // Zero-wait-state read on the 64-bit instance.
      htrans = 2'd2; hwrite = 1'b0; haddr = 32'h0004_0010; hburst = 3'd0;
      tick();
      htrans = 2'd0; hsel_b = 1'b0;
      chk("b_rd_c1_hready", 64'(hready_b), 64'd0);
      tick();
      chk("b_rd_c2_hready", 64'(hready_b), 64'd1);
      chk("b_rd_c2_data", hrdata_b, bd[0]);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
